// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage with IDLE/BUSY memory handshake, abort after TIMEOUT busy cycles, sticky err.
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] ALU,
  input  logic [31:0] B,
  input  logic [4:0]  reg_dst,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        alu_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ALU_output,
  output logic [31:0] LMD,
  output logic [4:0]  reg_dst_o,
  output logic        mem_write,
  output logic        alu_write_o,
  output logic        valid_o,
  output logic        stall,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [4:0]    rd_q, rd_d;
  logic          ld_q, ld_d, st_q, st_d;
  logic [31:0]   alu_out_q, alu_out_d, lmd_q, lmd_d;
  logic [4:0]    rd_o_q, rd_o_d;
  logic          mw_q, mw_d, aw_q, aw_d, v_q, v_d, err_q, err_d;
  logic          mem_op, last;
  // The cycle holding count TIMEOUT-1 is the TIMEOUT-th busy cycle, so the abort lands after exactly TIMEOUT cycles
  assign last = cnt_q == CW'(TIMEOUT - 1);
  assign mem_op = is_load | is_store;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rd_d = rd_q;
    ld_d = ld_q;
    st_d = st_q;
    alu_out_d = alu_out_q;
    lmd_d = lmd_q;
    rd_o_d = rd_o_q;
    mw_d = 1'b0;
    aw_d = 1'b0;
    v_d = 1'b0;
    err_d = err_q;
    if (state_q == IDLE) begin
      if (valid_in && !mem_op) begin
        alu_out_d = ALU;
        rd_o_d = reg_dst;
        aw_d = alu_write;
        v_d = 1'b1;
      end else if (valid_in) begin
        state_d = BUSY;
        cnt_d = '0;
        addr_d = ALU;
        wdata_d = B;
        rd_d = reg_dst;
        ld_d = is_load;
        st_d = is_store;
      end
    end else if (mem_ack) begin
      state_d = IDLE;
      alu_out_d = addr_q;
      rd_o_d = rd_q;
      v_d = 1'b1;
      mw_d = ld_q;
      lmd_d = ld_q ? mem_rdata : lmd_q;
    end else if (last) begin
      state_d = IDLE;
      err_d = 1'b1;
      v_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      ld_q <= 1'b0;
      st_q <= 1'b0;
      alu_out_q <= '0;
      lmd_q <= '0;
      rd_o_q <= '0;
      mw_q <= 1'b0;
      aw_q <= 1'b0;
      v_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      ld_q <= ld_d;
      st_q <= st_d;
      alu_out_q <= alu_out_d;
      lmd_q <= lmd_d;
      rd_o_q <= rd_o_d;
      mw_q <= mw_d;
      aw_q <= aw_d;
      v_q <= v_d;
      err_q <= err_d;
    end
  end
  assign stall = state_q == BUSY ? !(mem_ack || last) : valid_in && mem_op;
  assign mem_req = state_q == BUSY;
  assign mem_we = state_q == BUSY && st_q;
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign ALU_output = alu_out_q;
  assign LMD = lmd_q;
  assign reg_dst_o = rd_o_q;
  assign mem_write = mw_q;
  assign alu_write_o = aw_q;
  assign valid_o = v_q;
  assign err = err_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and random transactions against a transaction-level model of the MEM stage.
module tb_mem_access;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, is_load = 1'b0, is_store = 1'b0, alu_write = 1'b0;
  logic [31:0] ALU = '0, B = '0, mem_rdata = '0;
  logic [4:0] reg_dst = '0;
  logic mem_ack = 1'b0;
  logic mem_req, mem_we, mem_write, alu_write_o, valid_o, stall, err;
  logic [31:0] mem_addr, mem_wdata, ALU_output, LMD;
  logic [4:0] reg_dst_o;
  int n_vec = 0, n_bad = 0;
  logic [31:0] exp_alu = '0, exp_lmd = '0;
  logic [4:0] exp_rd = '0;
  logic exp_err = 1'b0, known = 1'b1;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ALU(ALU), .B(B), .reg_dst(reg_dst),
    .is_load(is_load), .is_store(is_store), .alu_write(alu_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ALU_output(ALU_output), .LMD(LMD),
    .reg_dst_o(reg_dst_o), .mem_write(mem_write), .alu_write_o(alu_write_o),
    .valid_o(valid_o), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input logic v, input logic aw, input logic mw, input logic chk_data);
    chk("valid_o", 32'(valid_o), 32'(v));
    chk("alu_write_o", 32'(alu_write_o), 32'(aw));
    chk("mem_write", 32'(mem_write), 32'(mw));
    chk("LMD", LMD, exp_lmd);
    chk("err", 32'(err), 32'(exp_err));
    chk("mem_req_after", 32'(mem_req), 32'd0);
    if (chk_data && known) begin
      chk("ALU_output", ALU_output, exp_alu);
      chk("reg_dst_o", 32'(reg_dst_o), 32'(exp_rd));
    end
  endtask

  // kind 0: ALU op, 1: load, 2: store; d: busy cycle in which ack arrives (d > TO means never)
  task automatic op(input int kind, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                    input logic aw, input int d, input logic [31:0] rdata);
    logic ack;
    valid_in = 1'b1; ALU = a; B = b; reg_dst = rd; alu_write = aw;
    is_load = kind == 1; is_store = kind == 2; mem_ack = 1'b0;
    #1;
    chk("stall_issue", 32'(stall), 32'(kind != 0));
    chk("mem_req_issue", 32'(mem_req), 32'd0);
    @(negedge clk);
    if (kind != 0) begin
      for (int c = 1; c <= TO; c++) begin
        chk("mem_req_busy", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("mem_we", 32'(mem_we), 32'(kind == 2));
        chk("mem_wdata", mem_wdata, b);
        chk("valid_busy", 32'(valid_o), 32'd0);
        ack = c == d;
        mem_ack = ack;
        mem_rdata = ack ? rdata : $urandom;
        #1;
        chk("stall_busy", 32'(stall), 32'(!(ack || c == TO)));
        @(negedge clk);
        if (ack) break;
      end
    end
    valid_in = 1'b0; mem_ack = 1'b0; is_load = 1'b0; is_store = 1'b0;
    #1;
    if (kind != 0 && d > TO) begin
      exp_err = 1'b1;
      known = 1'b0;
      chk_out(1'b1, 1'b0, 1'b0, 1'b0);
    end else begin
      exp_alu = a; exp_rd = rd; known = 1'b1;
      if (kind == 1) exp_lmd = rdata;
      chk_out(1'b1, kind == 0 ? aw : 1'b0, kind == 1, 1'b1);
    end
  endtask

  task automatic idle();
    valid_in = 1'b0;
    mem_ack = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk_out(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_zero();
    exp_alu = '0; exp_rd = '0; exp_lmd = '0; exp_err = 1'b0; known = 1'b1;
    chk_out(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero();
    op(0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 32'h0);
    idle();
    op(1, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 3, 32'hCAFE_F00D);
    op(2, 32'h0000_0200, 32'hA5A5_A5A5, 5'd9, 1'b0, 1, 32'h0);
    idle();
    op(1, 32'h0000_0300, 32'h0, 5'd3, 1'b0, TO, 32'h1111_2222);
    op(1, 32'h0000_0400, 32'h0, 5'd4, 1'b0, TO + 1, 32'h0);
    idle();
    op(1, 32'h0000_0500, 32'h0, 5'd10, 1'b0, 1, 32'hAAAA_0001);
    op(1, 32'h0000_0504, 32'h0, 5'd11, 1'b0, 1, 32'hBBBB_0002);
    idle();
    valid_in = 1'b1; ALU = 32'h0000_0600; is_load = 1'b1; reg_dst = 5'd12;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0; is_load = 1'b0;
    #1;
    chk_zero();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk_zero();
    for (int i = 0; i < 40; i++) begin
      op(int'($urandom_range(0, 2)), $urandom, $urandom, 5'($urandom), 1'($urandom),
         int'($urandom_range(1, TO + 2)), $urandom);
      if ($urandom_range(0, 2) == 0) idle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
